// File: rtl/led_pattern_ctrl.sv
// N-LED pattern generator: key pulses cycle the display mode and the step rate,
// and a programmable step counter advances the pattern at the selected period.
module led_pattern_ctrl #(
   parameter int unsigned LED_W  = 4,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned TICK_0 = 62_500_000,
   parameter int unsigned TICK_1 = 125_000_000,
   parameter int unsigned TICK_2 = 250_000_000,
   parameter int unsigned TICK_3 = 625_000_000
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             mode_pulse,
   input  logic             speed_pulse,
   input  logic             pause,
   output logic [LED_W-1:0] led,
   output logic [2:0]       mode,
   output logic [1:0]       speed,
   output logic             step_tick
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ROT_L  = 3'd1,
      ROT_R  = 3'd2,
      BOUNCE = 3'd3,
      TOGGLE = 3'd4
   } mode_e;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   localparam logic [CNT_W-1:0] LAST_0 = CNT_W'(TICK_0 - 1);
   localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(TICK_1 - 1);
   localparam logic [CNT_W-1:0] LAST_2 = CNT_W'(TICK_2 - 1);
   localparam logic [CNT_W-1:0] LAST_3 = CNT_W'(TICK_3 - 1);

   // Toggle seed: every odd-numbered LED lit (4'b1010 for four LEDs)
   function automatic logic [LED_W-1:0] odd_bits();
      logic [LED_W-1:0] m;
      m = '0;
      for (int unsigned i = 1; i < LED_W; i += 2) m[i] = 1'b1;
      return m;
   endfunction

   localparam logic [LED_W-1:0] SEED_ROT_L  = LED_W'(1);
   localparam logic [LED_W-1:0] SEED_ROT_R  = {1'b1, {(LED_W-1){1'b0}}};
   localparam logic [LED_W-1:0] SEED_TOGGLE = odd_bits();

   function automatic logic [CNT_W-1:0] period_last(input logic [1:0] s);
      case (s)
         2'd0:    return LAST_0;
         2'd1:    return LAST_1;
         2'd2:    return LAST_2;
         default: return LAST_3;
      endcase
   endfunction

   mode_e            state_q, state_d;
   dir_e             dir_q, dir_d;
   logic [1:0]       speed_q, speed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             step_q, step_d;
   logic [LED_W-1:0] shifted;

   // State register
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= DIR_UP;
         speed_q <= 2'd0;
         cnt_q   <= '0;
         led_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         speed_q <= speed_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         step_q  <= step_d;
      end
   end

   // Next-state: pattern step first, then speed and mode pulses override cnt/pattern
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      speed_d = speed_q;
      cnt_d   = cnt_q;
      led_d   = led_q;
      step_d  = 1'b0;
      shifted = '0;

      if (state_q == IDLE) begin
         speed_d = 2'd0;
         cnt_d   = '0;
         led_d   = '0;
         dir_d   = DIR_UP;
         if (mode_pulse) begin
            state_d = ROT_L;
            led_d   = SEED_ROT_L;
         end
      end else begin
         if (!pause) begin
            if (cnt_q == period_last(speed_q)) begin
               cnt_d = '0;
               case (state_q)
                  ROT_L:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                  ROT_R:  led_d = {led_q[0], led_q[LED_W-1:1]};
                  TOGGLE: led_d = ~led_q;
                  BOUNCE: begin
                     // Direction flips as the lit bit lands on an end, so ends show once
                     if (dir_q == DIR_UP) begin
                        shifted = led_q << 1;
                        if (shifted[LED_W-1]) dir_d = DIR_DN;
                     end else begin
                        shifted = led_q >> 1;
                        if (shifted[0]) dir_d = DIR_UP;
                     end
                     led_d = shifted;
                  end
                  default: led_d = led_q;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         if (speed_pulse) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = '0;
         end

         if (mode_pulse) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            case (state_q)
               ROT_L: begin
                  state_d = ROT_R;
                  led_d   = SEED_ROT_R;
               end
               ROT_R: begin
                  state_d = BOUNCE;
                  led_d   = SEED_ROT_L;
               end
               BOUNCE: begin
                  state_d = TOGGLE;
                  led_d   = SEED_TOGGLE;
               end
               TOGGLE: begin
                  state_d = ROT_L;
                  led_d   = SEED_ROT_L;
               end
               default: begin
                  state_d = IDLE;
                  led_d   = '0;
               end
            endcase
         end
      end

      // Registered flag is high exactly during the cycle in which cnt sits at P-1
      step_d = (state_d != IDLE) && !pause && (cnt_d == period_last(speed_d));
   end

   assign led       = led_q;
   assign mode      = state_q;
   assign speed     = speed_q;
   assign step_tick = step_q;

endmodule
